// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

  localparam int unsigned ADDR_LEN = 32;
  localparam int unsigned INST_LEN = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

  // 128 direct-mapped entries of one word each
  localparam int unsigned ICACHE_INDEX_W_DEFAULT = 7;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_WAIT_MEM,
    IF_DRAIN
  } if_state_e;

  function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] addr);
    return {addr[ADDR_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: one word per entry, combinational lookup,
// synchronous fill. Only the valid bits are cleared by reset.
module if_icache
  import if_stage_pkg::*;
#(
  parameter int unsigned INDEX_W = ICACHE_INDEX_W_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INDEX_W-1:0]              rd_index,
  input  logic [ADDR_LEN-INDEX_W-3:0]     rd_tag,
  output logic                            hit,
  output logic [INST_LEN-1:0]             rd_data,
  input  logic                            wr_en,
  input  logic [INDEX_W-1:0]              wr_index,
  input  logic [ADDR_LEN-INDEX_W-3:0]     wr_tag,
  input  logic [INST_LEN-1:0]             wr_data
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam int unsigned TAG_W = ADDR_LEN - INDEX_W - 2;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [INST_LEN-1:0] data_q [DEPTH];

  // Valid bits: cleared on reset, set by a fill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays: written on fill, never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  // Combinational lookup
  always_comb begin
    hit     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    rd_data = data_q[rd_index];
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, I-cache lookup, MEMCTRL miss handling,
// stall and redirect handling, registered outputs towards IF_ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned          ICACHE_INDEX_W = ICACHE_INDEX_W_DEFAULT,
  parameter logic [ADDR_LEN-1:0]  RESET_PC       = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 jump_enable_i,
  input  logic [ADDR_LEN-1:0]  jump_pc_i,
  output logic                 if_req_o,
  output logic [ADDR_LEN-1:0]  if_addr_o,
  input  logic                 mem_ready_i,
  input  logic [INST_LEN-1:0]  mem_inst_i,
  output logic [ADDR_LEN-1:0]  pc_o,
  output logic [INST_LEN-1:0]  inst_o,
  output logic                 inst_valid_o
);

  if_state_e           state;
  logic [ADDR_LEN-1:0] pc;
  logic [ADDR_LEN-1:0] pc_next_seq;
  logic                cache_hit;
  logic [INST_LEN-1:0] cache_data;
  logic                fill_en;

  // Fill from the latched request address, which stays correct after a redirect
  always_comb begin
    pc_next_seq = pc + 32'd4;
    fill_en     = (state != IF_IDLE) && mem_ready_i;
  end

  if_icache #(
    .INDEX_W (ICACHE_INDEX_W)
  ) u_icache (
    .clk      (clk),
    .rst      (rst),
    .rd_index (pc[ICACHE_INDEX_W+1:2]),
    .rd_tag   (pc[ADDR_LEN-1:ICACHE_INDEX_W+2]),
    .hit      (cache_hit),
    .rd_data  (cache_data),
    .wr_en    (fill_en),
    .wr_index (if_addr_o[ICACHE_INDEX_W+1:2]),
    .wr_tag   (if_addr_o[ADDR_LEN-1:ICACHE_INDEX_W+2]),
    .wr_data  (mem_inst_i)
  );

  // Fetch FSM with pc and all outputs registered; redirect beats stall everywhere
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IF_IDLE;
      pc           <= RESET_PC;
      if_req_o     <= DISABLE;
      if_addr_o    <= '0;
      pc_o         <= '0;
      inst_o       <= ZERO_WORD;
      inst_valid_o <= DISABLE;
    end else begin
      unique case (state)
        IF_IDLE: begin
          if (jump_enable_i) begin
            pc           <= jump_pc_i;
            inst_valid_o <= DISABLE;
          end else if (cache_hit) begin
            if (!stall_i) begin
              pc_o         <= pc;
              inst_o       <= cache_data;
              inst_valid_o <= ENABLE;
              pc           <= pc_next_seq;
            end
          end else begin
            // Miss: request goes out even while stalled
            if_req_o  <= ENABLE;
            if_addr_o <= word_align(pc);
            state     <= IF_WAIT_MEM;
            if (!stall_i) begin
              inst_valid_o <= DISABLE;
            end
          end
        end

        IF_WAIT_MEM: begin
          if (jump_enable_i) begin
            pc           <= jump_pc_i;
            inst_valid_o <= DISABLE;
            if (mem_ready_i) begin
              if_req_o <= DISABLE;
              state    <= IF_IDLE;
            end else begin
              state <= IF_DRAIN;
            end
          end else if (mem_ready_i) begin
            if_req_o <= DISABLE;
            state    <= IF_IDLE;
            if (!stall_i) begin
              pc_o         <= pc;
              inst_o       <= mem_inst_i;
              inst_valid_o <= ENABLE;
              pc           <= pc_next_seq;
            end
          end else if (!stall_i) begin
            inst_valid_o <= DISABLE;
          end
        end

        IF_DRAIN: begin
          inst_valid_o <= DISABLE;
          if (jump_enable_i) begin
            pc <= jump_pc_i;
          end
          if (mem_ready_i) begin
            if_req_o <= DISABLE;
            state    <= IF_IDLE;
          end
        end

        default: begin
          state <= IF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage with a behavioural memory,
// cache-content model and expected instruction stream.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        jump_enable_i;
  logic [31:0] jump_pc_i;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_inst_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_stage #(
    .ICACHE_INDEX_W (7),
    .RESET_PC       (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .jump_enable_i (jump_enable_i),
    .jump_pc_i     (jump_pc_i),
    .if_req_o      (if_req_o),
    .if_addr_o     (if_addr_o),
    .mem_ready_i   (mem_ready_i),
    .mem_inst_i    (mem_inst_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Memory contents: a fixed scramble of the word address (word 0 is a NOP)
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  // Expected stream of presented instructions since the last redirect/reset
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_run(input logic [31:0] target);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.pc   = target + 32'(4 * i);
      e.inst = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Model of which words the cache should currently hold
  bit          m_valid [128];
  logic [22:0] m_tag   [128];

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[8:2]] && (m_tag[a[8:2]] == a[31:9]);
  endfunction

  // Output monitor: reset state, redirect kill, stall hold, in-order stream
  logic [31:0] prev_pc, prev_inst;
  logic        prev_valid;
  exp_t        got;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("rst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_req",   32'(if_req_o), 32'd0);
      check("rst_pc_o",  pc_o, 32'd0);
      check("rst_inst",  inst_o, 32'd0);
    end else if (jump_enable_i) begin
      check("jump_kill_valid", 32'(inst_valid_o), 32'd0);
    end else if (stall_i) begin
      check("stall_hold_pc",    pc_o, prev_pc);
      check("stall_hold_inst",  inst_o, prev_inst);
      check("stall_hold_valid", 32'(inst_valid_o), 32'(prev_valid));
    end else if (inst_valid_o) begin
      if (exp_q.size() == 0) begin
        check("stream_underflow", 32'd1, 32'd0);
      end else begin
        got = exp_q.pop_front();
        check("stream_pc",   pc_o, got.pc);
        check("stream_inst", inst_o, got.inst);
      end
    end
    prev_pc    = pc_o;
    prev_inst  = inst_o;
    prev_valid = inst_valid_o;
  end

  // Memory responder: answers one request at a time after a random latency
  bit          outstanding = 0;
  logic [31:0] raddr;
  int unsigned delay;
  int unsigned n_req = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      outstanding = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else if (mem_ready_i) begin
      m_valid[raddr[8:2]] = 1;
      m_tag[raddr[8:2]]   = raddr[31:9];
      outstanding = 0;
      check("req_drop_after_ready", 32'(if_req_o), 32'd0);
    end else if (outstanding) begin
      check("req_hold",  32'(if_req_o), 32'd1);
      check("addr_hold", if_addr_o, raddr);
    end else if (if_req_o) begin
      raddr = if_addr_o;
      n_req++;
      check("req_only_on_miss", 32'(model_hit(raddr)), 32'd0);
      if (exp_q.size() != 0)
        check("req_addr_is_pc", raddr, {exp_q[0].pc[31:2], 2'b00});
      outstanding = 1;
      delay = $urandom_range(0, 4);
    end
    @(negedge clk);
    if (outstanding && delay == 0 && !rst) begin
      mem_ready_i = 1'b1;
      mem_inst_i  = mem_word(raddr);
    end else begin
      mem_ready_i = 1'b0;
      mem_inst_i  = $urandom;
      if (outstanding && delay != 0) delay--;
    end
  end

  function automatic logic [31:0] pick_target();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'h0000_0008;
      2: return 32'h0000_0100;
      3: return 32'h0000_0200;
      4: return 32'h0000_0010;
      5: return 32'hFFFF_FFF8;
      6: return 32'h0000_0102;
      default: return 32'($urandom_range(0, 1023)) << 2;
    endcase
  endfunction

  task automatic random_phase(input int unsigned cycles);
    int unsigned since_jump = 0;
    logic [31:0] t;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      stall_i = ($urandom % 4) == 0;
      if (($urandom % 12) == 0 || since_jump >= 100) begin
        t = pick_target();
        jump_enable_i = 1'b1;
        jump_pc_i     = t;
        push_run(t);
        since_jump = 0;
      end else begin
        jump_enable_i = 1'b0;
        jump_pc_i     = $urandom;
        since_jump++;
      end
    end
    @(negedge clk);
    stall_i = 1'b0;
    jump_enable_i = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    @(negedge clk);
    jump_enable_i = 1'b1;
    jump_pc_i     = t;
    push_run(t);
    @(negedge clk);
    jump_enable_i = 1'b0;
  endtask

  bit found;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; jump_enable_i = 1'b0; jump_pc_i = '0;
    mem_ready_i = 1'b0; mem_inst_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_run(32'h0);

    // Cold start: request for RESET_PC on the first edge after release
    @(posedge clk); #1;
    check("cold_req",   32'(if_req_o), 32'd1);
    check("cold_addr",  if_addr_o, 32'h0);
    check("cold_valid", 32'(inst_valid_o), 32'd0);

    random_phase(3000);

    // Reset during a miss: cache 0, start a miss elsewhere, reset in WAIT_MEM
    redirect(32'h0);
    repeat (20) @(negedge clk);
    redirect(32'h7000_0040);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (if_req_o && if_addr_o == 32'h7000_0040 && !mem_ready_i) found = 1;
    end
    check("midmiss_req_seen", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_run(32'h0);
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(posedge clk); #1;
      if (if_req_o && if_addr_o == 32'h0) found = 1;
    end
    check("reset_refetch_miss", 32'(found), 32'd1);

    random_phase(1500);

    repeat (40) @(negedge clk);
    check("requests_issued", 32'(n_req > 20), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
